// File: rtl/iter_alu.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus
// iterative unsigned multiply (shift-add) and divide (restoring).
module iter_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CTRL_WIDTH-1:0] alu_control,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] alu_out_hi,
    output logic                  equal,
    output logic                  overflow,
    output logic                  div_zero
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam int SH_WIDTH  = $clog2(DATA_WIDTH);
    localparam int W         = DATA_WIDTH;

    localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] OP_PASSB = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] OP_SLL   = CTRL_WIDTH'(7);
    localparam logic [CTRL_WIDTH-1:0] OP_SRL   = CTRL_WIDTH'(8);
    localparam logic [CTRL_WIDTH-1:0] OP_SRA   = CTRL_WIDTH'(9);
    localparam logic [CTRL_WIDTH-1:0] OP_MULU  = CTRL_WIDTH'(10);
    localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(11);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]         op_a;
    logic [W-1:0]         acc_hi;
    logic [W-1:0]         acc_lo;

    logic                 is_mul, is_div_iter, single_op;
    logic [W-1:0]         sum, diff, res, res_hi;
    logic                 ovf, dz;
    logic [SH_WIDTH-1:0]  sh;

    logic [W:0]           mul_sum;
    logic [W-1:0]         mul_hi_next, mul_lo_next;
    logic [W:0]           div_shift, div_trial;
    logic [W-1:0]         div_rem_next, div_quo_next;

    assign busy        = (state != IDLE);
    assign is_mul      = (alu_control == OP_MULU);
    assign is_div_iter = (alu_control == OP_DIVU) && (src_b != '0);
    assign single_op   = !(is_mul || is_div_iter);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && is_mul)           state_next = MUL;
                else if (start && is_div_iter) state_next = DIV;
            end
            MUL, DIV: begin
                if (cnt == CNT_WIDTH'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result of every op that completes in the same edge it is issued.
    always_comb begin
        res    = '0;
        res_hi = '0;
        ovf    = 1'b0;
        dz     = 1'b0;
        sum    = src_a + src_b;
        diff   = src_a - src_b;
        sh     = src_b[SH_WIDTH-1:0];
        case (alu_control)
            OP_ADD: begin
                res = sum;
                ovf = (src_a[W-1] == src_b[W-1]) && (sum[W-1] != src_a[W-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (src_a[W-1] != src_b[W-1]) && (diff[W-1] != src_a[W-1]);
            end
            OP_PASSB: res = src_b;
            OP_AND:   res = src_a & src_b;
            OP_OR:    res = src_a | src_b;
            OP_XOR:   res = src_a ^ src_b;
            OP_SLT:   res = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLL:   res = src_a << sh;
            OP_SRL:   res = src_a >> sh;
            OP_SRA:   res = $unsigned($signed(src_a) >>> sh);
            OP_DIVU: begin
                res    = '1;
                res_hi = src_a;
                dz     = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration step; the last step's values go straight to the outputs.
    always_comb begin
        mul_sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
        {mul_hi_next, mul_lo_next} = {mul_sum, acc_lo[W-1:1]};
        div_shift    = {acc_hi, acc_lo[W-1]};
        div_trial    = div_shift - {1'b0, op_a};
        div_rem_next = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
        div_quo_next = {acc_lo[W-2:0], ~div_trial[W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_a       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            done       <= 1'b0;
            alu_out    <= '0;
            alu_out_hi <= '0;
            equal      <= 1'b1;
            overflow   <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && single_op) begin
                        alu_out    <= res;
                        alu_out_hi <= res_hi;
                        equal      <= (res == '0);
                        overflow   <= ovf;
                        div_zero   <= dz;
                        done       <= 1'b1;
                    end else if (start) begin
                        cnt    <= CNT_WIDTH'(W);
                        acc_hi <= '0;
                        op_a   <= is_mul ? src_a : src_b;
                        acc_lo <= is_mul ? src_b : src_a;
                    end
                end
                MUL: begin
                    cnt    <= cnt - CNT_WIDTH'(1);
                    acc_hi <= mul_hi_next;
                    acc_lo <= mul_lo_next;
                    if (cnt == CNT_WIDTH'(1)) begin
                        alu_out    <= mul_lo_next;
                        alu_out_hi <= mul_hi_next;
                        equal      <= (mul_lo_next == '0);
                        overflow   <= 1'b0;
                        div_zero   <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                DIV: begin
                    cnt    <= cnt - CNT_WIDTH'(1);
                    acc_hi <= div_rem_next;
                    acc_lo <= div_quo_next;
                    if (cnt == CNT_WIDTH'(1)) begin
                        alu_out    <= div_quo_next;
                        alu_out_hi <= div_rem_next;
                        equal      <= (div_quo_next == '0);
                        overflow   <= 1'b0;
                        div_zero   <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at DATA_WIDTH=32.
module tb_iter_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] alu_out;
    logic [31:0] alu_out_hi;
    logic        equal;
    logic        overflow;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    iter_alu #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .alu_out(alu_out), .alu_out_hi(alu_out_hi), .equal(equal),
        .overflow(overflow), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge and drop start afterwards.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; alu_control = op; src_a = a; src_b = b;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; alu_control = '0; src_a = '0; src_b = '0;
        #2;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_tests++; if (alu_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out got %h want 0", alu_out); end
        n_tests++; if (alu_out_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi got %h want 0", alu_out_hi); end
        n_tests++; if (equal !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_equal got %b want 1", equal); end
        n_tests++; if (overflow !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags got ovf=%b dz=%b want 0 0", overflow, div_zero); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_overflow();
        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL add_done got %b want 1", done); end
        n_tests++; if (alu_out !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL add_out got %h want 80000000", alu_out); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL add_ovf got %b want 1", overflow); end
        n_tests++; if (equal !== 1'b0) begin n_fail++; $display("[TB] FAIL add_equal got %b want 0", equal); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL add_busy got %b want 0", busy); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL add_done_pulse got %b want 0", done); end
        n_tests++; if (alu_out !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL add_hold got %h want 80000000", alu_out); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; alu_control = 4'd1; src_a = 32'd5; src_b = 32'd5;
        tick();
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_sub_hs got done=%b busy=%b want 1 0", done, busy); end
        n_tests++; if (alu_out !== 32'h0 || equal !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_sub got %h eq=%b want 0 eq=1", alu_out, equal); end
        alu_control = 4'd6; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
        tick();
        start = 1'b0;
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_slt_hs got done=%b busy=%b want 1 0", done, busy); end
        n_tests++; if (alu_out !== 32'h1 || equal !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_slt got %h eq=%b want 1 eq=0", alu_out, equal); end
        tick();
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_ovf;
    } vec_t;

    task automatic test_single_ops();
        vec_t v[11];
        v[0]  = '{4'd3,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
        v[1]  = '{4'd4,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
        v[2]  = '{4'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
        v[3]  = '{4'd2,  32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        v[4]  = '{4'd7,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0};
        v[5]  = '{4'd8,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
        v[6]  = '{4'd9,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
        v[7]  = '{4'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        v[8]  = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        v[9]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        v[10] = '{4'd13, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0};
        for (int i = 0; i < 11; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            n_tests++;
            if (done !== 1'b1 || alu_out !== v[i].exp || alu_out_hi !== 32'h0 || overflow !== v[i].exp_ovf
                || equal !== (v[i].exp == 32'h0) || div_zero !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL op%0d_vec%0d got out=%h hi=%h ovf=%b eq=%b dz=%b done=%b want out=%h hi=0 ovf=%b dz=0 done=1",
                         v[i].op, i, alu_out, alu_out_hi, overflow, equal, div_zero, done, v[i].exp, v[i].exp_ovf);
            end
        end
        tick();
    endtask

    task automatic test_mulu();
        int cycles;
        int busy_cycles;
        issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0002);
        cycles = 1; busy_cycles = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cycles++;
            if (cycles == 10) begin
                start = 1'b1; alu_control = 4'd0; src_a = 32'd1; src_b = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        n_tests++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL mul_latency got %0d want 33", cycles); end
        n_tests++; if (busy_cycles !== 32) begin n_fail++; $display("[TB] FAIL mul_busy_cycles got %0d want 32", busy_cycles); end
        n_tests++; if (alu_out !== 32'hFFFF_FFFE || alu_out_hi !== 32'h1) begin n_fail++; $display("[TB] FAIL mul_result got %h:%h want 00000001:fffffffe", alu_out_hi, alu_out); end
        n_tests++; if (busy !== 1'b0 || equal !== 1'b0 || overflow !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_flags got busy=%b eq=%b ovf=%b dz=%b want 0 0 0 0", busy, equal, overflow, div_zero); end
        issue(4'd0, 32'd2, 32'd2);
        n_tests++; if (done !== 1'b1 || alu_out !== 32'd4 || alu_out_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL start_in_done got done=%b out=%h hi=%h want 1 4 0", done, alu_out, alu_out_hi); end
        tick();
    endtask

    task automatic test_divu();
        int cycles;
        int busy_cycles;
        issue(4'd11, 32'd100, 32'd7);
        cycles = 1; busy_cycles = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cycles++;
            tick();
            cycles++;
        end
        n_tests++; if (cycles !== 33 || busy_cycles !== 32) begin n_fail++; $display("[TB] FAIL div_latency got %0d/%0d want 33/32", cycles, busy_cycles); end
        n_tests++; if (alu_out !== 32'd14 || alu_out_hi !== 32'd2) begin n_fail++; $display("[TB] FAIL div_result got q=%0d r=%0d want q=14 r=2", alu_out, alu_out_hi); end
        n_tests++; if (div_zero !== 1'b0 || equal !== 1'b0) begin n_fail++; $display("[TB] FAIL div_flags got dz=%b eq=%b want 0 0", div_zero, equal); end
        tick();
    endtask

    task automatic test_div_zero();
        issue(4'd11, 32'd9, 32'd0);
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL dz_hs got done=%b busy=%b want 1 0", done, busy); end
        n_tests++; if (alu_out !== 32'hFFFF_FFFF || alu_out_hi !== 32'd9) begin n_fail++; $display("[TB] FAIL dz_result got %h:%h want 00000009:ffffffff", alu_out_hi, alu_out); end
        n_tests++; if (div_zero !== 1'b1 || equal !== 1'b0) begin n_fail++; $display("[TB] FAIL dz_flags got dz=%b eq=%b want 1 0", div_zero, equal); end
        tick();
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL dz_after got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_reset_mid_mul();
        int done_seen;
        issue(4'd10, 32'd5, 32'd6);
        for (int c = 1; c < 10; c++) tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_busy_before got %b want 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_hs got busy=%b done=%b want 0 0", busy, done); end
        n_tests++; if (alu_out !== 32'h0 || alu_out_hi !== 32'h0 || equal !== 1'b1 || div_zero !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_out got %h:%h eq=%b dz=%b want 0:0 eq=1 dz=0", alu_out_hi, alu_out, equal, div_zero); end
        tick(); tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) done_seen++;
        end
        n_tests++; if (done_seen !== 0) begin n_fail++; $display("[TB] FAIL rst_mid_no_done got %0d active cycles want 0", done_seen); end
        issue(4'd0, 32'd3, 32'd4);
        n_tests++; if (done !== 1'b1 || alu_out !== 32'd7) begin n_fail++; $display("[TB] FAIL rst_mid_add got done=%b out=%0d want 1 7", done, alu_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_single_ops();
        test_mulu();
        test_divu();
        test_div_zero();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
